read_prefetch: RTL and testbench

Read-side counterpart of the posted write buffer: a sequential read-ahead buffer between a read-mostly requester (instruction fetch, video scanout, DMA source) and the system bus. On a read miss it rebases a DEPTH-word window at the requested address, then fetches the window word by word in the background. Subsequent reads inside the window are served from local storage without a bus transaction. Writes pass through to the bus and invalidate stale window contents.

---
 rtl/read_prefetch.sv | 327 ++++++++++++++++++++++++++++++++
 tb/tb_read_prefetch.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/read_prefetch.sv
// read_prefetch: sequential read-ahead window between a read-mostly requester
// and the system bus. A read miss rebases a DEPTH-word window at the requested
// word and a background engine fills it word by word; later reads inside the
// window are served locally. Writes pass through to the bus and invalidate.
//
// Optional feature macro: READ_PREFETCH_SNOOP_EN
//   defined   - a write invalidates only when it hits the window, and the fill
//               restarts from the window start.
//   undefined - every write invalidates the whole window; no fill runs until
//               the next miss.
module read_prefetch #(
   parameter int DEPTH = 8
) (
   input  logic        i_reset,
   input  logic        i_clock,
   output logic        o_empty,
   output logic        o_busy,
   output logic        o_bus_rw,
   output logic        o_bus_request,
   input  logic        i_bus_ready,
   output logic [31:0] o_bus_address,
   input  logic [31:0] i_bus_rdata,
   output logic [31:0] o_bus_wdata,
   input  logic        i_rw,
   input  logic        i_request,
   output logic        o_ready,
   input  logic [31:0] i_address,
   output logic [31:0] o_rdata,
   input  logic [31:0] i_wdata
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FPTR_FULL = (PW+1)'(DEPTH);

`ifdef READ_PREFETCH_SNOOP_EN
   localparam bit SNOOP_EN = 1'b1;
`else
   localparam bit SNOOP_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      C_IDLE  = 2'd0,
      C_WAIT  = 2'd1,
      C_WRITE = 2'd2,
      C_ACK   = 2'd3
   } c_state_t;

   typedef enum logic [1:0] {
      B_IDLE  = 2'd0,
      B_FILL  = 2'd1,
      B_WRITE = 2'd2,
      B_TERM  = 2'd3
   } b_state_t;

   // window state
   logic [29:0]      base_q, base_d;
   logic [DEPTH-1:0] valid_q, valid_d;
   logic [31:0]      data_q [DEPTH];
   logic [31:0]      data_d [DEPTH];
   logic [PW:0]      fptr_q, fptr_d;
   logic             gen_q, gen_d;

   // client side
   c_state_t         c_state_q, c_state_d;
   logic [PW-1:0]    c_off_q, c_off_d;
   logic             ready_q, ready_d;
   logic [31:0]      rdata_q, rdata_d;

   // bus side
   b_state_t         b_state_q, b_state_d;
   logic             b_gen_q, b_gen_d;
   logic [PW-1:0]    b_idx_q, b_idx_d;
   logic             bus_req_q, bus_req_d;
   logic             bus_rw_q, bus_rw_d;
   logic [31:0]      bus_addr_q, bus_addr_d;
   logic [31:0]      bus_wdata_q, bus_wdata_d;

   logic             busy_q, busy_d;
   logic             empty_q, empty_d;

   // decode / handshake helpers
   logic [29:0]      off_full_s;
   logic [PW-1:0]    off_s;
   logic             in_window_s;
   logic             hit_s;
   logic             deliver_s;
   logic             rebase_s;
   logic             wr_inval_s;
   logic [29:0]      fill_word_s;

   // Window hit decode; a window whose remaining entries will never be filled counts as a miss.
   always_comb begin
      off_full_s  = i_address[31:2] - base_q;
      off_s       = off_full_s[PW-1:0];
      in_window_s = (off_full_s < 30'(DEPTH));
      hit_s       = in_window_s && (valid_q[off_s] || (fptr_q != FPTR_FULL));
      deliver_s   = (b_state_q == B_FILL) && i_bus_ready && (b_gen_q == gen_q);
   end

   // Client FSM: decides hits, misses and write invalidation; latches read data.
   always_comb begin
      c_state_d  = c_state_q;
      c_off_d    = c_off_q;
      rdata_d    = rdata_q;
      rebase_s   = 1'b0;
      wr_inval_s = 1'b0;
      case (c_state_q)
         C_IDLE: begin
            if (i_request) begin
               if (i_rw) begin
                  c_state_d = C_WRITE;
                  if (SNOOP_EN) begin
                     wr_inval_s = hit_s;
                  end else begin
                     wr_inval_s = 1'b1;
                  end
               end else if (hit_s) begin
                  c_off_d = off_s;
                  if (valid_q[off_s]) begin
                     rdata_d   = data_q[off_s];
                     c_state_d = C_ACK;
                  end else if (deliver_s && (b_idx_q == off_s)) begin
                     rdata_d   = i_bus_rdata;
                     c_state_d = C_ACK;
                  end else begin
                     c_state_d = C_WAIT;
                  end
               end else begin
                  rebase_s  = 1'b1;
                  c_off_d   = {PW{1'b0}};
                  c_state_d = C_WAIT;
               end
            end else begin
               c_state_d = C_IDLE;
            end
         end
         C_WAIT: begin
            if (valid_q[c_off_q]) begin
               rdata_d   = data_q[c_off_q];
               c_state_d = C_ACK;
            end else if (deliver_s && (b_idx_q == c_off_q)) begin
               rdata_d   = i_bus_rdata;
               c_state_d = C_ACK;
            end else begin
               c_state_d = C_WAIT;
            end
         end
         C_WRITE: begin
            if ((b_state_q == B_WRITE) && i_bus_ready) begin
               c_state_d = C_ACK;
            end else begin
               c_state_d = C_WRITE;
            end
         end
         C_ACK: begin
            if (!i_request) begin
               c_state_d = C_IDLE;
            end else begin
               c_state_d = C_ACK;
            end
         end
         default: begin
            c_state_d = C_IDLE;
         end
      endcase
      // o_ready follows one edge after the ACK decision and drops with the exit
      ready_d = (c_state_q == C_ACK) && (c_state_d == C_ACK);
   end

   // Window update: fill delivery first, then rebase/invalidation override it.
   always_comb begin
      base_d  = base_q;
      valid_d = valid_q;
      fptr_d  = fptr_q;
      gen_d   = gen_q;
      data_d  = data_q;
      if (deliver_s) begin
         data_d[b_idx_q]  = i_bus_rdata;
         valid_d[b_idx_q] = 1'b1;
         fptr_d           = fptr_q + {{PW{1'b0}}, 1'b1};
      end else begin
         fptr_d = fptr_q;
      end
      if (rebase_s) begin
         base_d  = i_address[31:2];
         valid_d = {DEPTH{1'b0}};
         fptr_d  = {(PW+1){1'b0}};
         gen_d   = ~gen_q;
      end else if (wr_inval_s) begin
         // gen also toggles here so a fill already on the bus cannot land stale data
         valid_d = {DEPTH{1'b0}};
         gen_d   = ~gen_q;
         if (SNOOP_EN) begin
            fptr_d = {(PW+1){1'b0}};
         end else begin
            fptr_d = FPTR_FULL;
         end
      end else begin
         base_d = base_q;
      end
   end

   // Bus FSM: client writes first, otherwise fetch the next window word.
   always_comb begin
      b_state_d   = b_state_q;
      b_gen_d     = b_gen_q;
      b_idx_d     = b_idx_q;
      bus_req_d   = bus_req_q;
      bus_rw_d    = bus_rw_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      fill_word_s = base_d + 30'(fptr_d);
      case (b_state_q)
         B_IDLE: begin
            if (c_state_d == C_WRITE) begin
               b_state_d   = B_WRITE;
               bus_req_d   = 1'b1;
               bus_rw_d    = 1'b1;
               bus_addr_d  = i_address;
               bus_wdata_d = i_wdata;
            end else if (fptr_d < FPTR_FULL) begin
               b_state_d   = B_FILL;
               b_gen_d     = gen_d;
               b_idx_d     = fptr_d[PW-1:0];
               bus_req_d   = 1'b1;
               bus_rw_d    = 1'b0;
               bus_addr_d  = {fill_word_s, 2'b00};
               bus_wdata_d = 32'h0;
            end else begin
               b_state_d = B_IDLE;
            end
         end
         B_FILL, B_WRITE: begin
            if (i_bus_ready) begin
               b_state_d   = B_TERM;
               bus_req_d   = 1'b0;
               bus_rw_d    = 1'b0;
               bus_addr_d  = 32'h0;
               bus_wdata_d = 32'h0;
            end else begin
               b_state_d = b_state_q;
            end
         end
         B_TERM: begin
            b_state_d = B_IDLE;
         end
         default: begin
            b_state_d   = B_IDLE;
            bus_req_d   = 1'b0;
            bus_rw_d    = 1'b0;
            bus_addr_d  = 32'h0;
            bus_wdata_d = 32'h0;
         end
      endcase
      busy_d  = (b_state_d != B_IDLE) || (fptr_d < FPTR_FULL) || (c_state_d == C_WRITE);
      empty_d = (valid_d == {DEPTH{1'b0}});
   end

   // Window storage registers; fill is parked at DEPTH until the first miss.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         base_q  <= 30'h0;
         valid_q <= {DEPTH{1'b0}};
         fptr_q  <= FPTR_FULL;
         gen_q   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= 32'h0;
         end
      end else begin
         base_q  <= base_d;
         valid_q <= valid_d;
         fptr_q  <= fptr_d;
         gen_q   <= gen_d;
         data_q  <= data_d;
      end
   end

   // Client FSM state and requester-facing outputs.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         c_state_q <= C_IDLE;
         c_off_q   <= {PW{1'b0}};
         ready_q   <= 1'b0;
         rdata_q   <= 32'h0;
      end else begin
         c_state_q <= c_state_d;
         c_off_q   <= c_off_d;
         ready_q   <= ready_d;
         rdata_q   <= rdata_d;
      end
   end

   // Bus FSM state, issuing tag and bus-facing outputs.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         b_state_q   <= B_IDLE;
         b_gen_q     <= 1'b0;
         b_idx_q     <= {PW{1'b0}};
         bus_req_q   <= 1'b0;
         bus_rw_q    <= 1'b0;
         bus_addr_q  <= 32'h0;
         bus_wdata_q <= 32'h0;
         busy_q      <= 1'b0;
         empty_q     <= 1'b1;
      end else begin
         b_state_q   <= b_state_d;
         b_gen_q     <= b_gen_d;
         b_idx_q     <= b_idx_d;
         bus_req_q   <= bus_req_d;
         bus_rw_q    <= bus_rw_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         busy_q      <= busy_d;
         empty_q     <= empty_d;
      end
   end

   assign o_empty       = empty_q;
   assign o_busy        = busy_q;
   assign o_bus_rw      = bus_rw_q;
   assign o_bus_request = bus_req_q;
   assign o_bus_address = bus_addr_q;
   assign o_bus_wdata   = bus_wdata_q;
   assign o_ready       = ready_q;
   assign o_rdata       = rdata_q;

endmodule

// File: tb/tb_read_prefetch.sv
// Bench for read_prefetch: a bus memory model answers requests with a
// configurable latency; read data is checked against that memory and bus
// traffic against the sequential-window fill rules.
module tb_read_prefetch;

   logic        i_reset;
   logic        i_clock;
   logic        o_empty;
   logic        o_busy;
   logic        o_bus_rw;
   logic        o_bus_request;
   logic        i_bus_ready;
   logic [31:0] o_bus_address;
   logic [31:0] i_bus_rdata;
   logic [31:0] o_bus_wdata;
   logic        i_rw;
   logic        i_request;
   logic        o_ready;
   logic [31:0] i_address;
   logic [31:0] o_rdata;
   logic [31:0] i_wdata;

   int checks = 0;
   int errors = 0;
   int bus_lat = 2;               // < 0 selects a random latency per transaction
   logic [32:0] bus_log [$];      // {rw, address} of every bus transaction
   logic [31:0] mem [logic [31:0]];

   logic        rsp_in_txn;
   logic        rsp_rw;
   logic [31:0] rsp_addr;
   int          rsp_wait;

   read_prefetch #(.DEPTH(8)) dut (
      .i_reset       (i_reset),
      .i_clock       (i_clock),
      .o_empty       (o_empty),
      .o_busy        (o_busy),
      .o_bus_rw      (o_bus_rw),
      .o_bus_request (o_bus_request),
      .i_bus_ready   (i_bus_ready),
      .o_bus_address (o_bus_address),
      .i_bus_rdata   (i_bus_rdata),
      .o_bus_wdata   (o_bus_wdata),
      .i_rw          (i_rw),
      .i_request     (i_request),
      .o_ready       (o_ready),
      .i_address     (i_address),
      .o_rdata       (o_rdata),
      .i_wdata       (i_wdata)
   );

   initial i_clock = 1'b0;
   always #5 i_clock = ~i_clock;

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return {~a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Bus slave: latches each request, holds it for bus_lat cycles, then strobes ready.
   initial begin
      rsp_in_txn  = 1'b0;
      rsp_rw      = 1'b0;
      rsp_addr    = 32'h0;
      rsp_wait    = 0;
      i_bus_ready = 1'b0;
      i_bus_rdata = 32'h0;
      forever begin
         @(negedge i_clock);
         i_bus_ready = 1'b0;
         i_bus_rdata = 32'h0;
         if (!i_reset) begin
            rsp_in_txn = 1'b0;
         end else if (o_bus_request) begin
            if (!rsp_in_txn) begin
               rsp_in_txn = 1'b1;
               rsp_rw     = o_bus_rw;
               rsp_addr   = o_bus_address;
               rsp_wait   = (bus_lat < 0) ? int'($urandom_range(0, 3)) : bus_lat;
               bus_log.push_back({rsp_rw, rsp_addr});
            end else begin
               check("bus_hold", {o_bus_rw, o_bus_address}, {rsp_rw, rsp_addr});
            end
            if (rsp_wait == 0) begin
               i_bus_ready = 1'b1;
               if (rsp_rw) mem[rsp_addr] = o_bus_wdata;
               else i_bus_rdata = mem_rd(rsp_addr);
               rsp_in_txn = 1'b0;
            end else begin
               rsp_wait--;
            end
         end else begin
            check("bus_idle_zero", {o_bus_rw, o_bus_address, o_bus_wdata}, 64'h0);
         end
      end
   end

   task automatic do_read(input logic [31:0] a, output logic [31:0] d, output int lat);
      int n;
      i_request = 1'b1;
      i_rw      = 1'b0;
      i_address = a;
      lat = 0;
      do begin
         @(negedge i_clock);
         lat++;
      end while (!o_ready && lat < 500);
      check("rd_ready", {63'h0, o_ready}, 64'h1);
      d = o_rdata;
      i_request = 1'b0;
      n = 0;
      do begin
         @(negedge i_clock);
         n++;
      end while (o_ready && n < 10);
      check("rd_ready_drop", {63'h0, o_ready}, 64'h0);
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] w);
      int n;
      i_request = 1'b1;
      i_rw      = 1'b1;
      i_address = a;
      i_wdata   = w;
      n = 0;
      do begin
         @(negedge i_clock);
         n++;
      end while (!o_ready && n < 500);
      check("wr_ready", {63'h0, o_ready}, 64'h1);
      i_request = 1'b0;
      i_rw      = 1'b0;
      n = 0;
      do begin
         @(negedge i_clock);
         n++;
      end while (o_ready && n < 10);
      check("wr_ready_drop", {63'h0, o_ready}, 64'h0);
      check("wr_mem", mem_rd(a), w);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((o_busy || o_bus_request) && n < 1000) begin
         @(negedge i_clock);
         n++;
      end
      check("idle_timeout", {62'h0, o_busy, o_bus_request}, 64'h0);
   endtask

   task automatic check_fill(input string tag, input int idx0, input logic [31:0] start, input int n);
      for (int i = 0; i < n; i++) begin
         logic [32:0] obs;
         obs = (idx0 + i < bus_log.size()) ? bus_log[idx0 + i] : 33'h1_FFFF_FFFF;
         check($sformatf("%s_addr%0d", tag, i), obs, {1'b0, start + 32'(4 * i)});
      end
   endtask

   initial begin
      #(2_000_000);
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      logic [31:0] a;
      logic [31:0] w;
      int lat;
      int n;

      i_reset   = 1'b0;
      i_request = 1'b0;
      i_rw      = 1'b0;
      i_address = 32'h0;
      i_wdata   = 32'h0;
      repeat (3) @(negedge i_clock);

      // reset state
      check("rst_empty", {63'h0, o_empty}, 64'h1);
      check("rst_busy", {63'h0, o_busy}, 64'h0);
      check("rst_ready", {63'h0, o_ready}, 64'h0);
      check("rst_rdata", {32'h0, o_rdata}, 64'h0);
      check("rst_bus", {o_bus_rw, o_bus_request, o_bus_address, o_bus_wdata}, 64'h0);
      i_reset = 1'b1;
      repeat (2) @(negedge i_clock);
      check("post_rst_busy", {63'h0, o_busy}, 64'h0);

      // cold miss at 0x1000: word 0 returned, whole window fetched in order
      bus_lat = 2;
      bus_log.delete();
      do_read(32'h1000, d, lat);
      check("s1_data", d, mem_rd(32'h1000));
      wait_idle();
      check("s1_count", bus_log.size(), 8);
      check_fill("s1", 0, 32'h1000, 8);
      check("s1_not_empty", {63'h0, o_empty}, 64'h0);

      // hits inside the filled window: no bus traffic, fixed latency
      bus_log.delete();
      for (int i = 1; i < 8; i++) begin
         a = 32'h1000 + 32'(4 * i);
         do_read(a, d, lat);
         check($sformatf("s2_data%0d", i), d, mem_rd(a));
         check($sformatf("s2_lat%0d", i), lat, 2);
      end
      check("s2_no_bus", bus_log.size(), 0);

      // rebase while the 0x1008 fill is in flight
      do_read(32'h5000, d, lat);
      wait_idle();
      bus_log.delete();
      do_read(32'h1000, d, lat);
      check("s3_data0", d, mem_rd(32'h1000));
      n = 0;
      while (!(o_bus_request && o_bus_address == 32'h1008) && n < 200) begin
         @(negedge i_clock);
         n++;
      end
      check("s3_saw_1008", {63'h0, o_bus_request}, 64'h1);
      do_read(32'h2000, d, lat);
      check("s3_data_2000", d, mem_rd(32'h2000));
      wait_idle();
      check("s3_count", bus_log.size(), 11);
      check_fill("s3a", 0, 32'h1000, 3);
      check_fill("s3b", 3, 32'h2000, 8);
      do_read(32'h2008, d, lat);
      check("s3_hit_data", d, mem_rd(32'h2008));
      check("s3_hit_lat", lat, 2);

      // window wrapping past the top of the address space
      bus_log.delete();
      do_read(32'hFFFF_FFF8, d, lat);
      check("s4_data", d, mem_rd(32'hFFFF_FFF8));
      wait_idle();
      check("s4_count", bus_log.size(), 8);
      check_fill("s4", 0, 32'hFFFF_FFF8, 8);
      bus_log.delete();
      do_read(32'h0000_0004, d, lat);
      check("s4_wrap_data", d, mem_rd(32'h0000_0004));
      check("s4_wrap_lat", lat, 2);
      check("s4_wrap_no_bus", bus_log.size(), 0);

      // write inside a filled window, then read it back
      do_read(32'h1000, d, lat);
      wait_idle();
      bus_log.delete();
      do_write(32'h1004, 32'hDEAD_BEEF);
      check("s5_wr_log", (bus_log.size() > 0) ? bus_log[0] : 33'h0, {1'b1, 32'h1004});
      wait_idle();
      do_read(32'h1004, d, lat);
      check("s5_data", d, 32'hDEAD_BEEF);
      wait_idle();
      check("s5_count", bus_log.size(), 9);
`ifdef READ_PREFETCH_SNOOP_EN
      check_fill("s5", 1, 32'h1000, 8);
`else
      check_fill("s5", 1, 32'h1004, 8);
`endif

      // reset asserted in the middle of a fill
      do_read(32'h7000, d, lat);
      n = 0;
      while (!o_bus_request && n < 200) begin
         @(negedge i_clock);
         n++;
      end
      check("s6_in_fill", {63'h0, o_bus_request}, 64'h1);
      #2;
      i_reset = 1'b0;
      #1;
      check("s6_req_drop", {63'h0, o_bus_request}, 64'h0);
      check("s6_empty", {63'h0, o_empty}, 64'h1);
      check("s6_ready", {63'h0, o_ready}, 64'h0);
      repeat (2) @(negedge i_clock);
      i_reset = 1'b1;
      @(negedge i_clock);
      bus_log.delete();
      do_read(32'h7010, d, lat);
      check("s6_data", d, mem_rd(32'h7010));
      check("s6_miss", (bus_log.size() > 0) ? bus_log[0] : 33'h0, {1'b0, 32'h7010});
      wait_idle();

      // random mix of reads and writes with random bus latency
      bus_lat = -1;
      for (int k = 0; k < 60; k++) begin
         a = 32'h1000 + 32'(4 * $urandom_range(0, 23));
         if ($urandom_range(0, 3) == 0) begin
            w = $urandom;
            do_write(a, w);
         end else begin
            do_read(a, d, lat);
            check($sformatf("rnd_data%0d", k), d, mem_rd(a));
         end
      end
      wait_idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
